// File: rtl/norm_round.sv
// Post-add normalizer and round-to-nearest-even stage for a float adder.
// Takes the unnormalized sum plus guard/round/sticky bits and returns a packed float with flags.
module norm_round #(
  parameter int N_float = 32,
  parameter int N_exp   = 8,
  parameter int N_mant  = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_in,
  input  logic [N_exp-1:0]    exp_in,
  input  logic [N_mant+1:0]   mant_in,
  input  logic [2:0]          grs_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_float-1:0]  float_R,
  output logic                overflow,
  output logic                underflow,
  output logic                inexact
);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, RENORM, DONE} state_t;

  localparam logic [N_mant+1:0] MANT_ONE = 1;
  localparam logic [N_exp:0]    EXP_ONE  = 1;
  localparam logic [N_exp:0]    EXP_MAX  = {1'b0, {N_exp{1'b1}}};

  state_t            state, state_n;
  logic [N_mant+1:0] mant_r, mant_n, mant_inc;
  logic [N_exp:0]    exp_r, exp_n, exp_inc, exp_dec;
  logic              g_r, r_r, s_r, g_n, r_n, s_n;
  logic              sign_r, sign_n;
  logic              ovf_r, unf_r, inx_r, ovf_n, unf_n, inx_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mant_r <= '0;
      exp_r  <= '0;
      g_r    <= 1'b0;
      r_r    <= 1'b0;
      s_r    <= 1'b0;
      sign_r <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
      inx_r  <= 1'b0;
    end else begin
      state  <= state_n;
      mant_r <= mant_n;
      exp_r  <= exp_n;
      g_r    <= g_n;
      r_r    <= r_n;
      s_r    <= s_n;
      sign_r <= sign_n;
      ovf_r  <= ovf_n;
      unf_r  <= unf_n;
      inx_r  <= inx_n;
    end
  end

  always_comb begin
    state_n  = state;
    mant_n   = mant_r;
    exp_n    = exp_r;
    g_n      = g_r;
    r_n      = r_r;
    s_n      = s_r;
    sign_n   = sign_r;
    ovf_n    = ovf_r;
    unf_n    = unf_r;
    inx_n    = inx_r;
    mant_inc = mant_r + MANT_ONE;
    exp_inc  = exp_r + EXP_ONE;
    exp_dec  = exp_r - EXP_ONE;

    case (state)
      IDLE: begin
        if (in_valid) begin
          mant_n  = mant_in;
          exp_n   = {1'b0, exp_in};
          {g_n, r_n, s_n} = grs_in;
          sign_n  = sign_in;
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          inx_n   = 1'b0;
          state_n = NORM;
        end
      end
      NORM: begin
        if (mant_r == '0 && {g_r, r_r, s_r} == 3'b000) begin
          sign_n  = 1'b0;
          exp_n   = '0;
          state_n = DONE;
        end else if (mant_r[N_mant+1]) begin
          mant_n = {1'b0, mant_r[N_mant+1:1]};
          g_n    = mant_r[0];
          r_n    = g_r;
          s_n    = r_r | s_r;
          // Reaching the all-ones exponent means the result is infinity.
          if (exp_inc >= EXP_MAX) begin
            exp_n   = EXP_MAX;
            mant_n  = '0;
            ovf_n   = 1'b1;
            state_n = DONE;
          end else begin
            exp_n   = exp_inc;
            state_n = ROUND;
          end
        end else if (!mant_r[N_mant]) begin
          // No denormals: a shift that would land on exponent 0 flushes to signed zero.
          if (exp_r <= EXP_ONE) begin
            mant_n  = '0;
            exp_n   = '0;
            unf_n   = 1'b1;
            state_n = DONE;
          end else begin
            mant_n = {mant_r[N_mant:0], g_r};
            g_n    = r_r;
            r_n    = 1'b0;
            exp_n  = exp_dec;
          end
        end else begin
          state_n = ROUND;
        end
      end
      ROUND: begin
        inx_n   = g_r | r_r | s_r;
        state_n = DONE;
        if (g_r & (r_r | s_r | mant_r[0])) begin
          mant_n = mant_inc;
          if (mant_inc[N_mant+1]) state_n = RENORM;
        end
      end
      RENORM: begin
        mant_n  = {1'b0, mant_r[N_mant+1:1]};
        state_n = DONE;
        if (exp_inc >= EXP_MAX) begin
          exp_n  = EXP_MAX;
          mant_n = '0;
          ovf_n  = 1'b1;
        end else begin
          exp_n  = exp_inc;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign float_R   = (state == DONE) ? {sign_r, exp_r[N_exp-1:0], mant_r[N_mant-1:0]} : '0;
  assign overflow  = ovf_r;
  assign underflow = unf_r;
  assign inexact   = inx_r;

endmodule

// File: tb/tb_norm_round.sv
// Directed-vector bench for norm_round: hand-computed results, flags and latencies.
module tb_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic [2:0]  grs_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_R;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int checks   = 0;
  int failures = 0;

  norm_round #(.N_float(32), .N_exp(8), .N_mant(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .grs_in    (grs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .float_R   (float_R),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one operand, measures edges from accept to out_valid, checks result, then drains.
  task automatic applyStimulus(input string tag, input logic s, input logic [7:0] e,
                               input logic [24:0] m, input logic [2:0] grs,
                               input logic [31:0] want_float, input logic [2:0] want_flags,
                               input int want_lat, input bit hold);
    int  lat;
    bit  seen;
    checkOutput({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
    grs_in   = grs;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(want_lat));
    checkOutput({tag, "_float"}, {32'd0, float_R}, {32'd0, want_float});
    checkOutput({tag, "_flags"}, {61'd0, overflow, underflow, inexact}, {61'd0, want_flags});
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        checkOutput({tag, "_hold_float"}, {32'd0, float_R}, {32'd0, want_float});
        checkOutput({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
        checkOutput({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({tag, "_release_in_ready"}, {63'd0, in_ready}, 64'd1);
    checkOutput({tag, "_release_out_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exp_in    = '0;
    mant_in   = '0;
    grs_in    = '0;
    #1;
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_float", {32'd0, float_R}, 64'd0);
    checkOutput("reset_flags", {61'd0, overflow, underflow, inexact}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //            tag            s     exp     mant_in      grs      float_R       flags   lat hold
    applyStimulus("one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 2,  1'b1);
    applyStimulus("shift23",      1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 3'b000, 25, 1'b0);
    applyStimulus("tie_renorm",   1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 3'b001, 3,  1'b0);
    applyStimulus("ovf_carry",    1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 3'b100, 1,  1'b0);
    applyStimulus("neg_zero",     1'b1, 8'd127, 25'h0000000, 3'b000, 32'h00000000, 3'b000, 1,  1'b0);
    applyStimulus("tie_even_dn",  1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001, 2,  1'b0);
    applyStimulus("round_up",     1'b0, 8'd127, 25'h0800000, 3'b101, 32'h3F800001, 3'b001, 2,  1'b0);
    applyStimulus("round_dn",     1'b0, 8'd127, 25'h0FFFFFF, 3'b011, 32'h3FFFFFFF, 3'b001, 2,  1'b0);
    applyStimulus("neg_one",      1'b1, 8'd127, 25'h0800000, 3'b000, 32'hBF800000, 3'b000, 2,  1'b0);
    applyStimulus("lshift_g_in",  1'b0, 8'd127, 25'h0400000, 3'b100, 32'h3F000001, 3'b000, 3,  1'b0);
    applyStimulus("carry_tie",    1'b0, 8'd127, 25'h1000001, 3'b000, 32'h40000000, 3'b001, 2,  1'b0);
    applyStimulus("carry_up",     1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 3'b001, 2,  1'b0);
    applyStimulus("min_exp",      1'b0, 8'd2,   25'h0400000, 3'b000, 32'h00800000, 3'b000, 3,  1'b0);
    applyStimulus("underflow",    1'b1, 8'd1,   25'h0400000, 3'b000, 32'h80000000, 3'b010, 1,  1'b0);
    applyStimulus("ovf_renorm",   1'b0, 8'd254, 25'h0FFFFFF, 3'b100, 32'h7F800000, 3'b101, 3,  1'b0);

    // Reset landing mid-normalization must abort without an edge and leave the block usable.
    sign_in  = 1'b0;
    exp_in   = 8'd127;
    mant_in  = 25'h0000001;
    grs_in   = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midrst_float", {32'd0, float_R}, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("after_rst",    1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 2,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/norm_round.md
NORM_ROUND -- requirements
Module: norm_round

Interface
REQ-001 Parameters: N_float, default 32, float width; N_exp, default 8, exponent width; N_mant, default 23, stored mantissa width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream adder datapath presents an unnormalized result.
REQ-005 in_ready  output  1  block idle and able to accept; high only in IDLE.
REQ-006 sign_in  input  1  result sign from the adder sign-select logic.
REQ-007 exp_in  input  N_exp  biased exponent of the larger operand.
REQ-008 mant_in  input  N_mant+2  {Cout, big-ALU sum}; bit N_mant is the hidden-1 position.
REQ-009 grs_in  input  3  guard, round, sticky bits shifted out during alignment (bit 2 = guard).
REQ-010 out_valid  output  1  float_R and flags valid.
REQ-011 out_ready  input  1  downstream consumes result.
REQ-012 float_R  output  N_float  packed {sign, exponent, mantissa} result.
REQ-013 overflow, underflow, inexact  output  1 each  exception flags, valid with out_valid.

Function
REQ-014 FSM states: IDLE, NORM, ROUND, RENORM, DONE; registered state, mantissa (N_mant+2), exponent (N_exp+1 internal), g/r/s, sign, flags.
REQ-015 IDLE: in_valid && in_ready latches all inputs and clears flags, -> NORM; otherwise stay.
REQ-016 NORM, mantissa and grs all zero: result +0 (sign forced 0), -> DONE.
REQ-017 NORM, bit N_mant+1 = 1: one-bit right shift, g<=old mantissa bit 0, r<=g, s<=r|s, exponent+1, -> ROUND.
REQ-018 NORM, bits N_mant+1 and N_mant both 0: one-bit left shift per cycle, g shifted into bit 0, g<=r, r<=0, s unchanged, exponent-1, stay NORM.
REQ-019 NORM, bit N_mant = 1 and bit N_mant+1 = 0: -> ROUND, no change.
REQ-020 Underflow: left shift that would make the exponent 0 instead flushes result to signed zero, sets underflow, -> DONE; no denormals produced.
REQ-021 ROUND: round-to-nearest-even; increment when g & (r | s | mantissa bit 0); inexact <= g|r|s.
REQ-022 ROUND: increment carrying into bit N_mant+1 -> RENORM; otherwise -> DONE.
REQ-023 RENORM: one-bit right shift, exponent+1, -> DONE.
REQ-024 Overflow: exponent reaching all-ones (2^N_exp-1) after any increment gives float_R = {sign, all-ones, zeros} (infinity), overflow=1, -> DONE.
REQ-025 DONE: out_valid=1, float_R = {sign, exponent[N_exp-1:0], mantissa[N_mant-1:0]}; held stable while out_ready=0; out_ready=1 -> IDLE.
REQ-026 Latency (accepting edge to out_valid high): zero 1 edge; normalized or carry input 2; plus 1 per left shift; plus 1 for RENORM.
REQ-027 in_valid ignored outside IDLE; no input buffering; one result in flight.
REQ-028 No simultaneous accept and emit: in_ready rises the cycle after DONE is left.

Reset
REQ-029 rst=1 immediately forces IDLE, in_ready=1, out_valid=0, float_R=0, overflow=underflow=inexact=0, regardless of clock or current state.
REQ-030 Reset mid-operation discards the in-flight result; no partial output is emitted.

Verification
REQ-031 sign 0, exp 127, mant_in 0x1000000, grs 000 (1.0+1.0) -> float_R 0x40000000, flags 0, out_valid 2 edges after accept.
REQ-032 exp 127, mant_in 0x0000001, grs 000 -> 23 left shifts, float_R 0x34000000, out_valid 25 edges after accept.
REQ-033 exp 127, mant_in 0x0FFFFFF, grs 100 -> tie rounds up, RENORM, float_R 0x40000000, inexact=1, latency 3.
REQ-034 exp 254, mant_in 0x1000000 -> float_R 0x7F800000, overflow=1; sign 1, mant 0, grs 0 -> float_R 0x00000000.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> float_R and out_valid stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle.
REQ-036 Assert rst during 23-shift normalization -> out_valid=0, in_ready=1 without a clock edge; the next accepted operand produces a correct result.
